// File: rtl/float_compare_sched.sv
// Round-robin scheduler that shares one combinational float comparator among
// NUM_REQ requesters for FEQ.S / FLT.S / FLE.S / FMIN.S / FMAX.S.

module float_comparator_comb (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        a_nan_o,
    output logic        b_nan_o,
    output logic        a_snan_o,
    output logic        b_snan_o,
    output logic        unordered_o,
    output logic        equal_o,
    output logic        less_o
);
    logic both_zero;
    logic mag_lt;
    logic mag_gt;

    assign a_nan_o     = (&a_i[30:23]) && (a_i[22:0] != 23'd0);
    assign b_nan_o     = (&b_i[30:23]) && (b_i[22:0] != 23'd0);
    assign a_snan_o    = a_nan_o && !a_i[22];
    assign b_snan_o    = b_nan_o && !b_i[22];
    assign unordered_o = a_nan_o || b_nan_o;
    assign both_zero   = (a_i[30:0] == 31'd0) && (b_i[30:0] == 31'd0);
    assign mag_lt      = a_i[30:0] < b_i[30:0];
    assign mag_gt      = a_i[30:0] > b_i[30:0];
    assign equal_o     = !unordered_o && ((a_i == b_i) || both_zero);

    // Sign-magnitude ordering: negative magnitudes compare in reverse.
    always_comb begin
        less_o = 1'b0;
        if (!unordered_o && !both_zero) begin
            if (a_i[31] != b_i[31]) begin
                less_o = a_i[31];
            end else if (a_i[31]) begin
                less_o = mag_gt;
            end else begin
                less_o = mag_lt;
            end
        end
    end
endmodule

module float_compare_sched #(
    parameter int          NUM_REQ   = 2,
    parameter int          ID_W      = 1,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic [4:0]            rsp_fflags,
    output logic [1:0]            dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // rsp_valid and the response payload stay stable until rsp_ready is seen.

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_FEQ  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FLE  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [4:0]      rsp_fflags_q, rsp_fflags_d;

    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [NUM_REQ-1:0]   rot_valid;
    logic                 grant_any;
    logic [ID_W:0]        grant_off;
    logic [ID_W:0]        grant_sum;
    logic [ID_W-1:0]      grant_id;
    logic                 req_fire;
    logic [31:0]          sel_a;
    logic [31:0]          sel_b;
    logic [2:0]           sel_op;

    logic        cmp_a_nan, cmp_b_nan, cmp_a_snan, cmp_b_snan;
    logic        cmp_unord, cmp_eq, cmp_lt;
    logic [31:0] eval_result;
    logic        eval_nv;

    // Rotating the valid vector by rr_ptr turns round-robin into a
    // lowest-set-bit search; the offset is then added back modulo NUM_REQ.
    assign dbl_valid = {req_valid, req_valid};
    assign rot_valid = NUM_REQ'(dbl_valid >> rr_ptr_q);

    always_comb begin
        grant_any = 1'b0;
        grant_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_any = 1'b1;
                grant_off = (ID_W+1)'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + grant_off;
        if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
        end
        grant_id = grant_sum[ID_W-1:0];
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_any) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (grant_id == ID_W'(i));
            end
        end
    end

    assign req_fire = (state_q == ST_IDLE) && grant_any;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[3*i +: 3];
            end
        end
    end

    float_comparator_comb u_cmp (
        .a_i         (a_q),
        .b_i         (b_q),
        .a_nan_o     (cmp_a_nan),
        .b_nan_o     (cmp_b_nan),
        .a_snan_o    (cmp_a_snan),
        .b_snan_o    (cmp_b_snan),
        .unordered_o (cmp_unord),
        .equal_o     (cmp_eq),
        .less_o      (cmp_lt)
    );

    always_comb begin
        eval_result = '0;
        eval_nv     = 1'b0;
        case (op_q)
            OP_FEQ: begin
                eval_result = {31'd0, cmp_eq};
                eval_nv     = cmp_a_snan || cmp_b_snan;
            end
            OP_FLT: begin
                eval_result = {31'd0, cmp_lt};
                eval_nv     = cmp_unord;
            end
            OP_FLE: begin
                eval_result = {31'd0, cmp_lt || cmp_eq};
                eval_nv     = cmp_unord;
            end
            OP_FMIN, OP_FMAX: begin
                eval_nv = cmp_a_snan || cmp_b_snan;
                if (cmp_a_nan && cmp_b_nan) begin
                    eval_result = CANON_NAN;
                end else if (cmp_a_nan) begin
                    eval_result = b_q;
                end else if (cmp_b_nan) begin
                    eval_result = a_q;
                end else if (cmp_eq) begin
                    // Only +0/-0 can be equal with differing signs.
                    if (a_q[31] != b_q[31]) begin
                        eval_result = ((op_q == OP_FMIN) == a_q[31]) ? a_q : b_q;
                    end else begin
                        eval_result = a_q;
                    end
                end else begin
                    eval_result = ((op_q == OP_FMIN) == cmp_lt) ? a_q : b_q;
                end
            end
            default: begin
                eval_result = '0;
                eval_nv     = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_fflags_d = rsp_fflags_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = grant_id;
                    state_d = ST_EVAL;
                    if (grant_id == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_id + 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                rsp_id_d     = id_q;
                rsp_result_d = eval_result;
                rsp_fflags_d = {eval_nv, 4'b0000};
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_fflags_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_fflags_q <= rsp_fflags_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_fflags = rsp_fflags_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_float_compare_sched.sv
// Bench for float_compare_sched: directed cases plus random traffic scored
// against an ordering-key model of the RISC-V compare/select rules.

module tb_float_compare_sched;
    localparam int          NUM_REQ = 2;
    localparam int          ID_W    = 1;
    localparam int          W       = ID_W + 37;
    localparam logic [31:0] CANON   = 32'h7FC00000;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*3-1:0]  req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic [4:0]            rsp_fflags;
    logic [1:0]            dbg_state;

    logic [31:0] opa [NUM_REQ];
    logic [31:0] opb [NUM_REQ];
    logic [2:0]  opc [NUM_REQ];

    logic [W-1:0]    exp_q[$];
    logic [ID_W-1:0] model_rr;
    logic [ID_W-1:0] last_g;
    int              cyc    = 0;
    int              errors = 0;
    int              checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
            req_op[3*i +: 3]  = opc[i];
        end
    end

    float_compare_sched #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W),
        .CANON_NAN (CANON)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_fflags (rsp_fflags),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Total order over non-NaN values as a signed integer; -0 and +0 map to 0.
    function automatic longint fkey(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        bit an, bn, as, bs, un, nv;
        longint ka, kb;
        logic [31:0] r, mn, mx;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        as = an && !a[22];
        bs = bn && !b[22];
        un = an || bn;
        ka = fkey(a);
        kb = fkey(b);
        r  = '0;
        nv = 1'b0;
        case (op)
            3'd0: begin r = {31'd0, (!un && ka == kb)}; nv = as || bs; end
            3'd1: begin r = {31'd0, (!un && ka < kb)};  nv = un; end
            3'd2: begin r = {31'd0, (!un && ka <= kb)}; nv = un; end
            3'd3, 3'd4: begin
                nv = as || bs;
                if (ka < kb) begin mn = a; mx = b; end
                else if (kb < ka) begin mn = b; mx = a; end
                else if (a[31] && !b[31]) begin mn = a; mx = b; end
                else if (b[31] && !a[31]) begin mn = b; mx = a; end
                else begin mn = a; mx = a; end
                if (an && bn) r = CANON;
                else if (an) r = b;
                else if (bn) r = a;
                else r = (op == 3'd3) ? mn : mx;
            end
            default: begin r = '0; nv = 1'b0; end
        endcase
        return {r, nv, 4'b0000};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [22:0] m;
        logic        s;
        logic [31:0] x;
        m = 23'($urandom);
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: x = {s, 8'hFF, 1'b1, m[21:0]};
            1: begin
                if (m[21:0] == 22'd0) m[0] = 1'b1;
                x = {s, 8'hFF, 1'b0, m[21:0]};
            end
            2: x = {s, 31'd0};
            3: x = {s, 8'hFF, 23'd0};
            default: x = {s, 8'($urandom_range(120, 134)), m};
        endcase
        return x;
    endfunction

    function automatic logic [31:0] rand_b(input logic [31:0] a);
        case ($urandom_range(0, 3))
            0: return a;
            1: return {~a[31], a[30:0]};
            default: return rand_fp();
        endcase
    endfunction

    task automatic set_req(input logic [ID_W-1:0] i, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        opa[i] = a;
        opb[i] = b;
        opc[i] = op;
        req_valid[i] = 1'b1;
    endtask

    // Called at a falling edge with the DUT idle: checks the grant, performs
    // the request handshake, then scores the response with rsp_ready held low
    // for 'delay' cycles.
    task automatic do_round(input int delay);
        logic [ID_W-1:0]    g, idx;
        logic               found;
        logic [NUM_REQ-1:0] oh;
        logic [W-1:0]       e;
        int                 hs, seen;
        #1;
        found = 1'b0;
        g     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(model_rr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        oh = '0;
        if (found) oh[g] = 1'b1;
        check("req_ready_grant", 64'(req_ready), 64'(oh));
        if (!found || req_ready == '0) return;
        @(posedge clk);
        #1;
        hs = cyc;
        exp_q.push_back({g, model(opa[g], opb[g], opc[g])});
        last_g       = g;
        model_rr     = ID_W'((int'(g) + 1) % NUM_REQ);
        req_valid[g] = 1'b0;
        seen = -1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = cyc;
                break;
            end
        end
        check("rsp_latency", 64'(seen + 1 - hs), 64'd2);
        e = exp_q.pop_front();
        if (seen < 0) return;
        check("rsp_id", 64'(rsp_id), 64'(e[W-1 -: ID_W]));
        check("rsp_result", 64'(rsp_result), 64'(e[36:5]));
        check("rsp_fflags", 64'(rsp_fflags), 64'(e[4:0]));
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_payload", 64'({rsp_id, rsp_result, rsp_fflags}), 64'(e));
            check("hold_no_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        model_rr  = '0;
        last_g    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
            opc[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_rsp_result", 64'(rsp_result), 64'd0);
        check("reset_rsp_fflags", 64'(rsp_fflags), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        reset_n = 1'b1;

        // Reset while a response is pending: it must vanish immediately.
        @(negedge clk);
        set_req(1'b0, 32'h3F800000, 32'h40000000, 3'b001);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midresp_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midresp_rsp_result", 64'(rsp_result), 64'd0);
        check("midresp_state", 64'(dbg_state), 64'd0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        model_rr = '0;

        // Directed op cases.
        set_req(1'b0, 32'h3F800000, 32'h40000000, 3'b001); do_round(0);
        set_req(1'b1, 32'h7FC00000, 32'h00000000, 3'b010); do_round(0);
        set_req(1'b0, 32'h7FC00000, 32'h00000000, 3'b000); do_round(1);
        set_req(1'b1, 32'h7F800001, 32'h00000000, 3'b000); do_round(0);
        set_req(1'b0, 32'h00000000, 32'h80000000, 3'b011); do_round(0);
        set_req(1'b1, 32'h00000000, 32'h80000000, 3'b100); do_round(0);
        set_req(1'b0, 32'h7F800001, 32'h3F800000, 3'b100); do_round(0);
        set_req(1'b1, 32'h7FC00000, 32'h7FC00000, 3'b011); do_round(0);

        // Both requesters continuously valid: grants must alternate 0,1,0,1.
        set_req(1'b0, 32'h3F800000, 32'hBF800000, 3'b011);
        set_req(1'b1, 32'hC0000000, 32'h40400000, 3'b100);
        for (int i = 0; i < 4; i++) begin
            do_round((i == 1) ? 3 : 0);
            check("alternate_grant", 64'(last_g), 64'(i % 2));
            set_req(last_g, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        end
        req_valid = '0;

        // A request withdrawn before any edge leaves no trace.
        @(negedge clk);
        set_req(1'b1, 32'h40000000, 32'h3F800000, 3'b001);
        #1;
        check("withdraw_ready_seen", 64'(req_ready), 64'b10);
        req_valid = '0;
        #1;
        check("withdraw_ready_gone", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("withdraw_state_idle", 64'(dbg_state), 64'd0);

        // Illegal op still gets a response; the following op is unaffected.
        set_req(1'b0, 32'h3F800000, 32'h40000000, 3'b111); do_round(0);
        set_req(1'b1, 32'hBF800000, 32'h3F800000, 3'b001); do_round(0);

        // Random traffic with random withdrawal and response backpressure.
        for (int r = 0; r < 150; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && $urandom_range(0, 4) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    opa[i] = rand_fp();
                    set_req(ID_W'(i), opa[i], rand_b(opa[i]), 3'($urandom_range(0, 7)));
                end
            end
            if (req_valid == '0) begin
                opa[0] = rand_fp();
                set_req(ID_W'($urandom_range(0, NUM_REQ - 1)), opa[0], rand_b(opa[0]),
                        3'($urandom_range(0, 7)));
            end
            do_round($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
